// File: rtl/ysyx_25030081_mem_arbiter.sv
// Two-master (IFU=m0, LSU=m1) round-robin arbiter in front of one single-ported memory slave.
// Optional counters: define YSYX_25030081_ARB_PERF_EN to add perf_gnt0/perf_gnt1/perf_wait.
//
// state | meaning
// IDLE  | pick a winner, accept its request and latch the payload
// SREQ  | present the latched request to the slave until it is accepted
// SRSP  | forward the slave response to the granted master
module ysyx_25030081_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                m_req_valid,
  output logic [1:0]                m_req_ready,
  input  logic [2*ADDR_WIDTH-1:0]   m_addr,
  input  logic [1:0]                m_wen,
  input  logic [2*DATA_WIDTH-1:0]   m_wdata,
  input  logic [2*DATA_WIDTH/8-1:0] m_wmask,
  output logic [1:0]                m_rsp_valid,
  input  logic [1:0]                m_rsp_ready,
  output logic [DATA_WIDTH-1:0]     m_rdata,
  output logic                      s_req_valid,
  input  logic                      s_req_ready,
  output logic [ADDR_WIDTH-1:0]     s_addr,
  output logic                      s_wen,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  output logic [DATA_WIDTH/8-1:0]   s_wmask,
  input  logic                      s_rsp_valid,
  output logic                      s_rsp_ready,
  input  logic [DATA_WIDTH-1:0]     s_rdata
`ifdef YSYX_25030081_ARB_PERF_EN
  ,
  output logic [31:0]               perf_gnt0,
  output logic [31:0]               perf_gnt1,
  output logic [31:0]               perf_wait
`endif
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SREQ, SRSP} state_t;

  state_t                state, state_nxt;
  logic                  gnt, last_gnt, winner, accept, done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MW-1:0]         wmask_q;

  // A lone requester always wins; on a tie the master not served last wins.
  always_comb begin
    case (m_req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_gnt;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    m_req_ready = 2'b00;
    m_rsp_valid = 2'b00;
    s_req_valid = 1'b0;
    s_rsp_ready = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (|m_req_valid) begin
          accept              = 1'b1;
          m_req_ready[winner] = 1'b1;
          state_nxt           = SREQ;
        end
      end
      SREQ: begin
        s_req_valid = 1'b1;
        if (s_req_ready) state_nxt = SRSP;
      end
      SRSP: begin
        m_rsp_valid[gnt] = s_rsp_valid;
        s_rsp_ready      = m_rsp_ready[gnt];
        if (s_rsp_valid && m_rsp_ready[gnt]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload is only shown to the slave while the request is pending, so idle outputs stay 0.
  assign s_addr  = (state == SREQ) ? addr_q  : '0;
  assign s_wen   = (state == SREQ) ? wen_q   : 1'b0;
  assign s_wdata = (state == SREQ) ? wdata_q : '0;
  assign s_wmask = (state == SREQ) ? wmask_q : '0;
  assign m_rdata = s_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt     <= winner;
        addr_q  <= winner ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : m_addr[ADDR_WIDTH-1:0];
        wen_q   <= m_wen[winner];
        wdata_q <= winner ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
        wmask_q <= winner ? m_wmask[2*MW-1:MW]                 : m_wmask[MW-1:0];
      end
      if (done) last_gnt <= gnt;
    end
  end

`ifdef YSYX_25030081_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0 <= '0;
      perf_gnt1 <= '0;
      perf_wait <= '0;
    end else begin
      if (accept && !winner) perf_gnt0 <= perf_gnt0 + 32'd1;
      if (accept && winner)  perf_gnt1 <= perf_gnt1 + 32'd1;
      if ((|m_req_valid) && (m_req_ready == 2'b00)) perf_wait <= perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ysyx_25030081_mem_arbiter.md
Name: ysyx_25030081_mem_arbiter

Overview:
- Shares one single-ported memory slave between two bus masters: m0 = IFU (instruction fetch) and m1 = LSU (load/store).
- Sits between the multi-cycle core's fetch/LSU units and the SRAM/DPI memory model.
- Valid/ready handshake on both the request and the response channels.
- One outstanding transaction at a time; round-robin arbitration when both masters request together.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width. Mask width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req_valid  in  2  per-master request valid; bit i = master i.
- m_req_ready  out  2  per-master request accept.
- m_addr  in  2*ADDR_WIDTH  per-master address; slice i = master i.
- m_wen  in  2  per-master write enable (0 = read).
- m_wdata  in  2*DATA_WIDTH  per-master write data.
- m_wmask  in  2*DATA_WIDTH/8  per-master byte mask.
- m_rsp_valid  out  2  per-master response valid.
- m_rsp_ready  in  2  per-master response accept.
- m_rdata  out  DATA_WIDTH  read data, broadcast; meaningful only where m_rsp_valid is set.
- s_req_valid  out  1  slave request valid.
- s_req_ready  in  1  slave request accept.
- s_addr  out  ADDR_WIDTH  latched address.
- s_wen  out  1  latched write enable.
- s_wdata  out  DATA_WIDTH  latched write data.
- s_wmask  out  DATA_WIDTH/8  latched byte mask.
- s_rsp_valid  in  1  slave response valid.
- s_rsp_ready  out  1  slave response accept.
- s_rdata  in  DATA_WIDTH  slave read data.

Behaviour:
- Registers:
  - state ∈ {IDLE, SREQ, SRSP}.
  - gnt (1 bit): index of the master that owns the current transaction.
  - last_gnt (1 bit): master served most recently.
  - Request latches for addr, wen, wdata, wmask.
- Reset (rst=1 at a clock edge):
  - state=IDLE, gnt=0, last_gnt=1, so m0 wins the first tie.
  - All latches cleared to 0.
  - All outputs 0: m_req_ready, m_rsp_valid, s_req_valid, s_rsp_ready, s_addr, s_wen, s_wdata, s_wmask. m_rdata follows s_rdata.
- Reset mid-transaction:
  - The transaction is abandoned; no response is delivered.
  - The slave is reset by the same rst.
- IDLE:
  - Winner selection: if exactly one m_req_valid bit is set, that master wins. If both are set, the winner is ~last_gnt.
  - m_req_ready[winner]=1 combinationally in the same cycle. The other ready bit stays 0.
  - On that edge: latch the winner's addr/wen/wdata/wmask, set gnt=winner, go to SREQ.
  - No request: stay in IDLE, all outputs 0.
- SREQ:
  - s_req_valid=1, with s_* driven from the latches. Latches stay stable until accepted.
  - On s_req_ready=1: go to SRSP.
  - No timeout; waits indefinitely.
- SRSP:
  - m_rsp_valid[gnt]=s_rsp_valid; s_rsp_ready=m_rsp_ready[gnt]; m_rdata=s_rdata.
  - On s_rsp_valid & m_rsp_ready[gnt]: last_gnt=gnt, go to IDLE.
  - Writes also return a response; m_rdata is don't-care for writes.
- Latency:
  - Zero-wait slave (s_req_ready=1 and s_rsp_valid the cycle after acceptance): accept → SREQ → SRSP = 3 cycles per transaction.
  - Next accept occurs in the IDLE cycle that follows.
- Master rules:
  - A master holds valid and payload stable until ready.
  - A master may drop valid in IDLE before being accepted; it is not latched.
  - The non-granted master sees ready=0 and rsp_valid=0 throughout.
- Round-robin:
  - Both masters continuously requesting alternate strictly: m0, m1, m0, ...
  - A single requester is served back-to-back regardless of last_gnt.
- No combinational path from s_req_ready or s_rsp_valid to m_req_ready.

Optional Feature:
- Macro: YSYX_25030081_ARB_PERF_EN.
- When defined, add three outputs: perf_gnt0 (32), perf_gnt1 (32), perf_wait (32).
  - perf_gnt0/perf_gnt1 increment on each accept for master 0/1.
  - perf_wait increments each cycle any m_req_valid bit is set but no m_req_ready bit is set.
  - All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- m0 read, addr=0x80000000, zero-wait slave returning 0x00100073 → m_req_ready=2'b01 in cycle 0; s_req_valid in cycle 1 with s_addr=0x80000000; m_rsp_valid=2'b01 and m_rdata=0x00100073 in cycle 2; IDLE in cycle 3.
- m0 and m1 both valid from reset → grants in order m0, m1, m0, m1; last_gnt toggles after every completion.
- m1 write, addr=0x80001000, wdata=0xDEADBEEF, wmask=4'hF; slave holds s_req_ready=0 for 5 cycles → s_* stable for all 5 cycles; m_req_ready=0 to both masters; response is delivered after the slave accepts.
- m_rsp_ready[gnt]=0 for 3 cycles while s_rsp_valid=1 → s_rsp_ready=0 and state stays SRSP; completes on the cycle m_rsp_ready rises.
- Assert rst during SRSP → next cycle: state IDLE; all outputs 0; last_gnt=1; a subsequent dual request grants m0.
- With YSYX_25030081_ARB_PERF_EN defined: 4 alternating dual-request transactions → perf_gnt0=2, perf_gnt1=2; perf_wait equals the cycles spent in SREQ/SRSP with a pending request.
